ela_deint: RTL and testbench

Parametrised edge-based line average (ELA) deinterlacer. It reads a field line by line from the host image interface and writes a progressive frame to result memory. Even output rows are copies of field lines. Odd output rows are interpolated along the best of 2R+1 edge directions, or by plain vertical averaging in bypass mode. Field lines are held in ping-pong line buffers, so no line-to-line copy cycles are spent. The block sits between the field source and the frame memory, in the same position as the earlier fixed 128×32, 3-direction ELA.

---
 rtl/ela_pkg.sv | 34 +++
 rtl/ela_dir_select.sv | 35 +++
 rtl/ela_deint.sv | 204 ++++++++++++++++++++
 tb/tb_ela_deint.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ela_pkg.sv
// ela_pkg: shared definitions for the ELA deinterlacer.
//   state_t    controller states
//   PRIO_DIR   search directions in tie-break order (0, -1, +1, -2, +2, ...)
//   abs_diff   absolute difference of two pixel values
package ela_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD0,
        S_LOAD,
        S_INTERP,
        S_FIN
    } state_t;

    localparam int R_MAX = 3;
    localparam int N_MAX = 2*R_MAX + 1;

    // Odd slots hold the negative direction of each magnitude, so a plain
    // first-minimum scan already prefers smaller |d| and then negative d.
    function automatic int prio_dir(input int idx);
        return (idx % 2 == 1) ? -((idx + 1) / 2) : idx / 2;
    endfunction

    // A block of radius R uses the first 2R+1 entries.
    localparam int PRIO_DIR [N_MAX] = '{
        prio_dir(0), prio_dir(1), prio_dir(2), prio_dir(3),
        prio_dir(4), prio_dir(5), prio_dir(6)
    };

    function automatic int abs_diff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

endpackage

// File: rtl/ela_dir_select.sv
// ela_dir_select: combinational argmin over N candidate directions.
//   vld      per-direction valid flags, in tie-priority order
//   diff     per-direction |a-b|
//   avg      per-direction (a+b)>>1
//   avg_sel  average of the first valid candidate with the smallest diff
module ela_dir_select
    import ela_pkg::*;
#(
    parameter int N  = 3,
    parameter int DW = 8
) (
    input  logic [N-1:0]         vld,
    input  logic [N-1:0][DW-1:0] diff,
    input  logic [N-1:0][DW-1:0] avg,
    output logic [DW-1:0]        avg_sel
);

    logic          best_vld;
    logic [DW-1:0] best_diff;

    // Strict less-than keeps the earlier (higher-priority) entry on ties.
    always_comb begin
        best_vld  = vld[0];
        best_diff = diff[0];
        avg_sel   = avg[0];
        for (int j = 1; j < N; j++) begin
            if (vld[j] && (!best_vld || diff[j] < best_diff)) begin
                best_vld  = 1'b1;
                best_diff = diff[j];
                avg_sel   = avg[j];
            end
        end
    end

endmodule

// File: rtl/ela_deint.sv
// ela_deint: edge-based line average deinterlacer.
// Reads H field lines of W pixels and writes a (2H-1)-row progressive frame.
//   clk      rising-edge clock
//   rst      synchronous active-low reset
//   mode     0 = ELA, 1 = vertical average (latched in IDLE)
//   ready    in_data valid
//   in_data  field pixel, raster order
//   req      one-cycle pulse requesting the next field line
//   wen      result write strobe
//   addr     result address, row*W + col
//   data_wr  result pixel
//   done     frame complete, sticky until reset
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | latch mode, request line 0
// S_LOAD0  | store line 0, copy it to row 0
// S_LOAD   | store line k, copy it to row 2k
// S_INTERP | interpolate row 2k-1 from lines k-1 (T) and k (B)
// S_FIN    | frame complete, hold done
module ela_deint
    import ela_pkg::*;
#(
    parameter int W  = 128,
    parameter int H  = 32,
    parameter int DW = 8,
    parameter int R  = 1,
    parameter int AW = $clog2(W*(2*H-1))
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mode,
    input  logic          ready,
    input  logic [DW-1:0] in_data,
    output logic          req,
    output logic          wen,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] data_wr,
    output logic          done
);

    localparam int N  = 2*R + 1;
    localparam int CW = $clog2(W + 2);
    localparam int XW = $clog2(W);
    localparam int KW = $clog2(H) + 1;

    localparam logic [CW-1:0] COL_LAST  = CW'(W - 1);
    localparam logic [CW-1:0] COL_END   = CW'(W);
    localparam logic [CW-1:0] COL_DRAIN = CW'(W + 1);
    localparam logic [KW-1:0] K_LAST    = KW'(H - 1);
    localparam logic [AW-1:0] ROW_STEP  = AW'(2*W);
    localparam logic [AW-1:0] ROW_W     = AW'(W);

    state_t        state;
    logic          mode_r;
    logic          wp;
    logic [CW-1:0] col;
    logic [KW-1:0] k;
    logic [AW-1:0] row_base;    // address of row 2k

    logic [DW-1:0] lbuf [2][W];

    logic [N-1:0]         c_vld, s1_v;
    logic [N-1:0][DW-1:0] c_diff, c_avg, s1_diff, s1_avg;
    logic                 s1_vld;
    logic [AW-1:0]        s1_addr;
    logic [DW-1:0]        sel_avg;
    logic                 load_st;

    assign load_st = (state == S_LOAD0) || (state == S_LOAD);

    // Ping-pong line buffers: the new line lands in buffer[wp] while
    // buffer[~wp] still holds the previous line.
    always_ff @(posedge clk) begin
        if (rst && load_st && ready) begin
            lbuf[wp][col[XW-1:0]] <= in_data;
        end
    end

    // S1 candidates. Out-of-range directions read the centre pixel so the
    // buffer index never leaves the array; their valid flag is cleared.
    always_comb begin
        int            cc, d, ad;
        logic          v;
        logic [XW-1:0] ia, ib;
        logic [DW-1:0] a, b;
        c_vld  = '0;
        c_diff = '0;
        c_avg  = '0;
        cc = (int'(col) > W - 1) ? W - 1 : int'(col);
        for (int j = 0; j < N; j++) begin
            d  = PRIO_DIR[j];
            ad = (d < 0) ? -d : d;
            v  = (cc >= ad) && (cc + ad <= W - 1) && (!mode_r || d == 0);
            ia = v ? XW'(cc + d) : XW'(cc);
            ib = v ? XW'(cc - d) : XW'(cc);
            a  = lbuf[~wp][ia];
            b  = lbuf[wp][ib];
            c_vld[j]  = v;
            c_diff[j] = DW'(abs_diff(int'(a), int'(b)));
            c_avg[j]  = DW'((int'(a) + int'(b)) >> 1);
        end
    end

    ela_dir_select #(
        .N  (N),
        .DW (DW)
    ) u_dir_select (
        .vld     (s1_v),
        .diff    (s1_diff),
        .avg     (s1_avg),
        .avg_sel (sel_avg)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            mode_r   <= 1'b0;
            wp       <= 1'b0;
            col      <= '0;
            k        <= '0;
            row_base <= '0;
            req      <= 1'b0;
            wen      <= 1'b0;
            addr     <= '0;
            data_wr  <= '0;
            done     <= 1'b0;
            s1_vld   <= 1'b0;
            s1_addr  <= '0;
            s1_v     <= '0;
            s1_diff  <= '0;
            s1_avg   <= '0;
        end else begin
            req    <= 1'b0;
            wen    <= 1'b0;
            s1_vld <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    mode_r <= mode;
                    req    <= 1'b1;
                    state  <= S_LOAD0;
                end
                S_LOAD0, S_LOAD: begin
                    if (ready) begin
                        wen     <= 1'b1;
                        addr    <= row_base + AW'(col);
                        data_wr <= in_data;
                        if (col == COL_LAST) begin
                            col <= '0;
                            if (state == S_LOAD0) begin
                                wp       <= ~wp;
                                req      <= 1'b1;
                                k        <= k + KW'(1);
                                row_base <= row_base + ROW_STEP;
                                state    <= S_LOAD;
                            end else begin
                                state <= S_INTERP;
                            end
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                end
                S_INTERP: begin
                    // col runs W+2 cycles: W issue cycles plus two to drain S1/S2.
                    if (col < COL_END) begin
                        s1_vld  <= 1'b1;
                        s1_addr <= row_base - ROW_W + AW'(col);
                        s1_v    <= c_vld;
                        s1_diff <= c_diff;
                        s1_avg  <= c_avg;
                    end
                    if (s1_vld) begin
                        wen     <= 1'b1;
                        addr    <= s1_addr;
                        data_wr <= sel_avg;
                    end
                    if (col == COL_DRAIN) begin
                        col <= '0;
                        if (k == K_LAST) begin
                            done  <= 1'b1;
                            state <= S_FIN;
                        end else begin
                            wp       <= ~wp;
                            req      <= 1'b1;
                            k        <= k + KW'(1);
                            row_base <= row_base + ROW_STEP;
                            state    <= S_LOAD;
                        end
                    end else begin
                        col <= col + CW'(1);
                    end
                end
                S_FIN: begin
                    done <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ela_deint.sv
// tb_ela_deint: directed bench for ela_deint with W=8, H=4.
// Two instances share the stimulus: u_dut1 with R=1 and u_dut2 with R=2.
module tb_ela_deint;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int DW = 8;
    localparam int NA = W*(2*H-1);

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       mode = 1'b0;
    logic       ready = 1'b0;
    logic [7:0] in_data = 8'd0;

    logic       req1, wen1, done1, req2, wen2, done2;
    logic [5:0] addr1, addr2;
    logic [7:0] data1, data2;

    ela_deint #(.W(W), .H(H), .DW(DW), .R(1)) u_dut1 (
        .clk     (clk),
        .rst     (rst),
        .mode    (mode),
        .ready   (ready),
        .in_data (in_data),
        .req     (req1),
        .wen     (wen1),
        .addr    (addr1),
        .data_wr (data1),
        .done    (done1)
    );

    ela_deint #(.W(W), .H(H), .DW(DW), .R(2)) u_dut2 (
        .clk     (clk),
        .rst     (rst),
        .mode    (mode),
        .ready   (ready),
        .in_data (in_data),
        .req     (req2),
        .wen     (wen2),
        .addr    (addr2),
        .data_wr (data2),
        .done    (done2)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] fld [4][8];
    int mem1 [NA];
    int cnt1 [NA];
    int mem2 [NA];
    int cnt2 [NA];
    int nwr1, nwr2, bad1, cyc, last_wen, done_cyc, early_done;
    int gap_viol, n_gap, req_dbl;
    bit done_seen, req_prev, rdy_s, ld_s, loading, toggle, saw_row3;
    logic [5:0] addr_prev;

    task automatic check_val(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        for (int i = 0; i < NA; i++) begin
            mem1[i] = -1;
            cnt1[i] = 0;
            mem2[i] = -1;
            cnt2[i] = 0;
        end
        nwr1 = 0; nwr2 = 0; bad1 = 0; last_wen = 0; done_cyc = 0;
        early_done = 0; gap_viol = 0; n_gap = 0; req_dbl = 0;
        done_seen = 1'b0; saw_row3 = 1'b0;
    endtask

    always @(posedge clk) begin
        rdy_s = ready;
        ld_s  = loading;
    end

    always @(negedge clk) begin
        cyc++;
        if (wen1) begin
            if (addr1 < NA) begin
                mem1[addr1] = data1;
                cnt1[addr1]++;
            end else begin
                bad1++;
            end
            nwr1++;
            last_wen = cyc;
            if (addr1 >= 24 && addr1 < 32) saw_row3 = 1'b1;
        end
        if (wen2 && addr2 < NA) begin
            mem2[addr2] = data2;
            cnt2[addr2]++;
            nwr2++;
        end
        if (done1 && !done_seen) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
            if (nwr1 < NA) early_done++;
        end
        if (req1 && req_prev) req_dbl++;
        req_prev = req1;
        if (ld_s && !rdy_s) begin
            n_gap++;
            if (wen1 || addr1 != addr_prev) gap_viol++;
        end
        addr_prev = addr1;
    end

    task automatic wait_req(output int n);
        n = 0;
        while (!req1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("req_seen", int'(req1), 1);
    endtask

    task automatic feed_line(input int l);
        int c;
        bit ph;
        c  = 0;
        ph = 1'b1;
        loading = 1'b1;
        while (c < W) begin
            if (!toggle || ph) begin
                ready   = 1'b1;
                in_data = fld[l][c];
                c++;
            end else begin
                ready   = 1'b0;
                in_data = 8'hA5;
            end
            ph = !ph;
            @(negedge clk);
        end
        ready   = 1'b0;
        loading = 1'b0;
    endtask

    task automatic run_frame(input bit m, input bit tg, input bit do_rst, output int first_lat);
        int n, t;
        mode   = m;
        toggle = tg;
        if (do_rst) begin
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            @(negedge clk);
            clear_mon();
            rst = 1'b1;
        end
        first_lat = 0;
        for (int l = 0; l < H; l++) begin
            wait_req(n);
            if (l == 0) first_lat = n;
            feed_line(l);
        end
        t = 0;
        while (!done1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check_val("done_set", int'(done1), 1);
        repeat (3) @(negedge clk);
    endtask

    function automatic int even_rows_bad();
        int b = 0;
        for (int l = 0; l < H; l++)
            for (int c = 0; c < W; c++) begin
                if (mem1[16*l + c] != int'(fld[l][c])) b++;
                if (mem2[16*l + c] != int'(fld[l][c])) b++;
            end
        return b;
    endfunction

    function automatic int uniq1();
        int u = 0;
        for (int i = 0; i < NA; i++) if (cnt1[i] == 1) u++;
        return u;
    endfunction

    task automatic check_ela_values();
        check_val("r1c4_diag_R1", mem1[12], 255);
        check_val("r1c4_diag_R2", mem2[12], 255);
        check_val("r5c0_bound_R1", mem1[40], 100);
        check_val("r5c0_bound_R2", mem2[40], 100);
        check_val("r5c1_bound_R2", mem2[41], 70);
        check_val("r5c2_tie_R1", mem1[42], 50);
        check_val("r5c2_tie_R2", mem2[42], 50);
        check_val("r5c4_R1", mem1[44], 30);
        check_val("r5c4_R2", mem2[44], 0);
        check_val("r5c6_bound_R1", mem1[46], 15);
        check_val("r5c6_bound_R2", mem2[46], 15);
    endtask

    task automatic set_pattern();
        fld = '{'{8'd0,   8'd0,  8'd0,   8'd255, 8'd255, 8'd255, 8'd255, 8'd255},
                '{8'd0,   8'd0,  8'd0,   8'd0,   8'd0,   8'd255, 8'd255, 8'd255},
                '{8'd0,   8'd50, 8'd0,   8'd90,  8'd200, 8'd10,  8'd100, 8'd30},
                '{8'd201, 8'd90, 8'd255, 8'd50,  8'd100, 8'd200, 8'd0,   8'd20}};
    endtask

    initial begin
        int lat, bad, n;
        cyc = 0;
        loading = 1'b0;
        req_prev = 1'b0;
        addr_prev = '0;
        clear_mon();

        // Reset values
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_req", int'(req1), 0);
        check_val("rst_wen", int'(wen1), 0);
        check_val("rst_addr", int'(addr1), 0);
        check_val("rst_data", int'(data1), 0);
        check_val("rst_done", int'(done1), 0);

        // Flat field
        for (int l = 0; l < H; l++)
            for (int c = 0; c < W; c++) fld[l][c] = 8'h40;
        run_frame(1'b0, 1'b0, 1'b1, lat);
        check_val("flat_writes", nwr1, NA);
        check_val("flat_unique_addr", uniq1(), NA);
        check_val("flat_bad_addr", bad1, 0);
        bad = 0;
        for (int i = 0; i < NA; i++) begin
            if (mem1[i] != 8'h40) bad++;
            if (mem2[i] != 8'h40) bad++;
        end
        check_val("flat_values", bad, 0);
        check_val("flat_writes_R2", nwr2, NA);
        check_val("done_latency", done_cyc - last_wen, 1);
        check_val("done_sticky", int'(done1), 1);
        check_val("req_double", req_dbl, 0);

        // Edge pattern, ELA
        set_pattern();
        run_frame(1'b0, 1'b0, 1'b1, lat);
        check_val("pat_writes", nwr1, NA);
        check_val("pat_even_rows", even_rows_bad(), 0);
        check_ela_values();

        // Same pattern with ready toggling
        run_frame(1'b0, 1'b1, 1'b1, lat);
        check_val("tog_gap_cycles", n_gap, 28);
        check_val("tog_gap_hold", gap_viol, 0);
        check_val("tog_unique_addr", uniq1(), NA);
        check_val("tog_even_rows", even_rows_bad(), 0);
        check_ela_values();

        // Vertical-average mode
        run_frame(1'b1, 1'b0, 1'b1, lat);
        check_val("vavg_r1c4_R1", mem1[12], 127);
        check_val("vavg_r1c4_R2", mem2[12], 127);
        check_val("vavg_r5c2", mem1[42], 127);
        check_val("vavg_r5c4_R2", mem2[44], 150);
        check_val("vavg_r5c6", mem1[46], 50);

        // Reset in the middle of row-3 interpolation, then restart
        mode   = 1'b0;
        toggle = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clear_mon();
        rst = 1'b1;
        for (int l = 0; l < 3; l++) begin
            wait_req(n);
            feed_line(l);
        end
        repeat (5) @(negedge clk);
        check_val("mid_interp_row3", int'(saw_row3), 1);
        rst = 1'b0;
        @(negedge clk);
        check_val("mid_rst_req", int'(req1), 0);
        check_val("mid_rst_wen", int'(wen1), 0);
        check_val("mid_rst_addr", int'(addr1), 0);
        check_val("mid_rst_data", int'(data1), 0);
        check_val("mid_rst_done", int'(done1), 0);
        clear_mon();
        rst = 1'b1;
        run_frame(1'b0, 1'b0, 1'b0, lat);
        check_val("restart_req_lat", lat, 1);
        check_val("restart_writes", nwr1, NA);
        check_val("restart_unique_addr", uniq1(), NA);
        check_val("restart_done_early", early_done, 0);
        check_val("restart_even_rows", even_rows_bad(), 0);
        check_ela_values();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
